mem_stream_framer: RTL and testbench

Downstream consumer of the priority-encoder readout stream. Captures the gapped `mem_dat_stream`/`valid` words of each bunch crossing into a data FIFO. Wraps each crossing's words into a frame: header, data words, trailer. Emits frames on a ready/valid link interface, so a slow link can drain crossing N while crossing N+1 is still being merged.

---
 rtl/mem_stream_framer.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stream_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_framer.sv
// mem_stream_framer: buffers each crossing's stream words and emits header/data/trailer frames on a ready/valid link.
// Define FRAMER_CRC_EN to put a CRC-16-CCITT of the frame's data payloads into trailer[15:0].
`default_nettype none
module mem_stream_framer #(
  parameter int DATA_W  = 54,
  parameter int FIFO_AW = 6,
  parameter int EVQ_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_event,
  input  logic [2:0]        BX,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_valid,
  input  logic              in_none,
  output logic [DATA_W+1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_overflow,
  output logic              err_skip
);
  localparam int FDEPTH = 1 << FIFO_AW;
  localparam int EDEPTH = 1 << EVQ_AW;
  localparam logic [FIFO_AW-1:0] F_ONE = 1;
  localparam logic [EVQ_AW-1:0]  E_ONE = 1;
  localparam logic       CLOSED = 1'b0, OPEN = 1'b1;
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, DAT = 2'd2, TRL = 2'd3;

  logic              in_state;
  logic [1:0]        out_state;
  logic [DATA_W-1:0] mem [FDEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [FIFO_AW:0]  f_cnt;
  logic [2:0]        ev_bx   [EDEPTH];
  logic [6:0]        ev_cnt  [EDEPTH];
  logic [6:0]        ev_drop [EDEPTH];
  logic              ev_ovf  [EDEPTH];
  logic              ev_done [EDEPTH];
  logic [EVQ_AW-1:0] ev_wr, ev_rd, cur_slot;
  logic [EVQ_AW:0]   ev_occ;
  logic [2:0]        cur_bx;
  logic [6:0]        cur_cnt, cur_drop, rem;
  logic              cur_ovf;
  logic [1:0]        hold, none_run;

  logic hs, rd, pop, fifo_full, wr_ok, close, free, reserve, head_live, head_rdy;
  logic [2:0]        hd_bx;
  logic [6:0]        hd_cnt, hd_drop;
  logic              hd_ovf;
  logic [15:0]       crc_trl;
  logic [DATA_W-1:0] hdr_pl, trl_pl;

  assign hs        = out_valid & out_ready;
  assign rd        = hs & (out_state == DAT);
  assign pop       = hs & (out_state == TRL);
  assign rd_nxt    = rd_ptr + F_ONE;
  assign fifo_full = f_cnt[FIFO_AW];
  assign wr_ok     = (in_state == OPEN) & ~new_event & in_valid & (~fifo_full | rd);
  assign close     = (in_state == OPEN) &
                     (new_event | ((hold == 2'd0) & in_none & ~in_valid & (none_run == 2'd2)));
  assign free      = ~ev_occ[EVQ_AW] | pop;
  assign reserve   = new_event & free;

  // A record closing this cycle at the queue head is forwarded so its header can start next cycle.
  assign head_live = close & (cur_slot == ev_rd);
  assign head_rdy  = ev_done[ev_rd] | head_live;
  assign hd_bx     = head_live ? cur_bx   : ev_bx[ev_rd];
  assign hd_cnt    = head_live ? cur_cnt  : ev_cnt[ev_rd];
  assign hd_drop   = head_live ? cur_drop : ev_drop[ev_rd];
  assign hd_ovf    = head_live ? cur_ovf  : ev_ovf[ev_rd];

  always_comb begin
    hdr_pl = '0;
    hdr_pl[DATA_W-1 -: 3] = hd_bx;
    hdr_pl[DATA_W-4 -: 7] = hd_cnt;
    trl_pl = hdr_pl;
    trl_pl[DATA_W-11]      = hd_ovf;
    trl_pl[DATA_W-12 -: 7] = hd_drop;
    trl_pl[15:0]           = crc_trl;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_state     <= CLOSED;
      wr_ptr       <= '0;
      f_cnt        <= '0;
      ev_wr        <= '0;
      ev_occ       <= '0;
      cur_slot     <= '0;
      cur_bx       <= '0;
      cur_cnt      <= '0;
      cur_drop     <= '0;
      cur_ovf      <= 1'b0;
      hold         <= '0;
      none_run     <= '0;
      err_overflow <= 1'b0;
      err_skip     <= 1'b0;
      for (int i = 0; i < EDEPTH; i++) begin
        ev_bx[i]   <= '0;
        ev_cnt[i]  <= '0;
        ev_drop[i] <= '0;
        ev_ovf[i]  <= 1'b0;
        ev_done[i] <= 1'b0;
      end
    end else begin
      f_cnt  <= f_cnt + {{FIFO_AW{1'b0}}, wr_ok} - {{FIFO_AW{1'b0}}, rd};
      ev_occ <= ev_occ + {{EVQ_AW{1'b0}}, reserve} - {{EVQ_AW{1'b0}}, pop};
      if (wr_ok) wr_ptr <= wr_ptr + F_ONE;
      if (pop) ev_done[ev_rd] <= 1'b0;
      if (close) begin
        ev_bx[cur_slot]   <= cur_bx;
        ev_cnt[cur_slot]  <= cur_cnt;
        ev_drop[cur_slot] <= cur_drop;
        ev_ovf[cur_slot]  <= cur_ovf;
        ev_done[cur_slot] <= 1'b1;
        in_state          <= CLOSED;
      end
      if (new_event) begin
        if (free) begin
          in_state       <= OPEN;
          cur_slot       <= ev_wr;
          ev_wr          <= ev_wr + E_ONE;
          ev_done[ev_wr] <= 1'b0;
          cur_bx         <= BX;
          cur_cnt        <= '0;
          cur_drop       <= '0;
          cur_ovf        <= 1'b0;
          hold           <= 2'd3;
          none_run       <= '0;
        end else begin
          err_skip <= 1'b1;
        end
      end else if (in_state == OPEN) begin
        if (in_valid) begin
          none_run <= '0;
          if (wr_ok) begin
            cur_cnt <= cur_cnt + 7'd1;
          end else begin
            if (cur_drop != 7'h7F) cur_drop <= cur_drop + 7'd1;
            cur_ovf      <= 1'b1;
            err_overflow <= 1'b1;
          end
        end else if (hold == 2'd0) begin
          none_run <= in_none ? none_run + 2'd1 : 2'd0;
        end
        if (hold != 2'd0) hold <= hold - 2'd1;
      end
    end
  end

`ifdef FRAMER_CRC_EN
  logic [15:0] crc, crc_upd;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  assign crc_upd = crc_step(crc, out_word[DATA_W-1:0]);
  // The last data word's handshake is also the cycle the trailer loads, so fold it in directly.
  assign crc_trl = (out_state == DAT) ? crc_upd : crc;

  always_ff @(posedge clk) begin
    if (!reset || out_state == IDLE) crc <= 16'hFFFF;
    else if (rd)                     crc <= crc_upd;
  end
`else
  assign crc_trl = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state <= IDLE;
      out_valid <= 1'b0;
      out_word  <= '0;
      rem       <= '0;
      rd_ptr    <= '0;
      ev_rd     <= '0;
    end else begin
      case (out_state)
        IDLE: if (head_rdy) begin
          out_word  <= {2'b01, hdr_pl};
          out_valid <= 1'b1;
          rem       <= hd_cnt;
          out_state <= HDR;
        end
        HDR: if (hs) begin
          if (rem != 7'd0) begin
            out_word  <= {2'b00, mem[rd_ptr]};
            rem       <= rem - 7'd1;
            out_state <= DAT;
          end else begin
            out_word  <= {2'b10, trl_pl};
            out_state <= TRL;
          end
        end
        // rd_ptr tracks the word on the link; its slot frees only when that word handshakes.
        DAT: if (hs) begin
          rd_ptr <= rd_nxt;
          if (rem != 7'd0) begin
            out_word <= {2'b00, mem[rd_nxt]};
            rem      <= rem - 7'd1;
          end else begin
            out_word  <= {2'b10, trl_pl};
            out_state <= TRL;
          end
        end
        TRL: if (hs) begin
          out_valid <= 1'b0;
          out_word  <= '0;
          ev_rd     <= ev_rd + E_ONE;
          out_state <= IDLE;
        end
        default: out_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_stream_framer.sv
// tb_mem_stream_framer: random and directed stimulus checked against a frame-level model of mem_stream_framer.
`default_nettype none
module tb_mem_stream_framer;
  localparam int DW = 54;

  logic          clk = 1'b0, reset = 1'b0, new_event = 1'b0;
  logic          in_valid = 1'b0, in_none = 1'b0, out_ready = 1'b0;
  logic [2:0]    BX = '0;
  logic [DW-1:0] in_dat = '0;
  logic [DW+1:0] out_word;
  logic          out_valid, err_overflow, err_skip;

  always #5 clk = ~clk;

  mem_stream_framer dut (
    .clk(clk), .reset(reset), .new_event(new_event), .BX(BX),
    .in_dat(in_dat), .in_valid(in_valid), .in_none(in_none),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .err_overflow(err_overflow), .err_skip(err_skip)
  );

  int checks = 0, errors = 0;

  // Frame-level model: expected link words in order, plus occupancy bookkeeping.
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] seen[$];
  logic [DW-1:0] cur_w[$];
  int            nq = 0, nf = 0, hold = 0, none_run = 0, cur_drop = 0, cyc = 0;
  bit            open = 0, cur_ovf = 0, m_ovf = 0, m_skip = 0;
  logic [2:0]    cur_bx = '0;
  bit            prev_stall = 0, prev_rst = 0, rand_ready = 0;
  logic [DW+1:0] prev_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_close();
    logic [15:0] c;
    logic [6:0]  n;
    n = 7'(cur_w.size());
    c = 16'h0000;
`ifdef FRAMER_CRC_EN
    c = 16'hFFFF;
    foreach (cur_w[k])
      for (int b = DW - 1; b >= 0; b--)
        c = {c[14:0], 1'b0} ^ (((c[15] ^ cur_w[k][b]) != 1'b0) ? 16'h1021 : 16'h0000);
`endif
    exp_q.push_back({2'b01, cur_bx, n, 44'd0});
    foreach (cur_w[k]) exp_q.push_back({2'b00, cur_w[k]});
    exp_q.push_back({2'b10, cur_bx, n, cur_ovf, 7'(cur_drop), 20'd0, c});
    open = 0;
  endtask

  always @(negedge clk) begin : mon
    bit hs, pop, rd;
    cyc++;
    if (cyc > 2) begin
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_skip", err_skip, m_skip);
      if (prev_rst) begin
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_word", out_word, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", out_word, prev_word);
      end
    end
    hs  = reset && out_valid && out_ready;
    pop = hs && (out_word[DW+1:DW] == 2'b10);
    rd  = hs && (out_word[DW+1:DW] == 2'b00);
    if (hs) begin
      seen.push_back(out_word);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_word actual=%0h required=none", out_word);
      end else begin
        chk("frame_word", out_word, exp_q.pop_front());
      end
    end
    if (!reset) begin
      exp_q.delete(); cur_w.delete();
      open = 0; nq = 0; nf = 0; m_ovf = 0; m_skip = 0;
    end else begin
      if (open) begin
        if (new_event) model_close();
        else begin
          if (in_valid) begin
            none_run = 0;
            if (nf < 64 || rd) begin cur_w.push_back(in_dat); nf++; end
            else begin
              if (cur_drop < 127) cur_drop++;
              cur_ovf = 1; m_ovf = 1;
            end
          end else if (hold == 0 && in_none) begin
            none_run++;
            if (none_run == 3) model_close();
          end else if (hold == 0) none_run = 0;
          if (hold > 0) hold--;
        end
      end
      if (new_event) begin
        if (nq < 4 || pop) begin
          nq++; open = 1; cur_bx = BX; cur_w.delete();
          cur_drop = 0; cur_ovf = 0; hold = 3; none_run = 0;
        end else m_skip = 1;
      end
      if (pop) nq--;
      if (rd) nf--;
    end
    prev_stall = reset && out_valid && !out_ready;
    prev_word  = out_word;
    prev_rst   = !reset;
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic ev(input logic [2:0] b);
    new_event = 1; BX = b; tick(); new_event = 0;
  endtask

  task automatic put(input logic [DW-1:0] d);
    in_valid = 1; in_dat = d; tick(); in_valid = 0;
  endtask

  task automatic close_none();
    in_none = 1; repeat (6) tick(); in_none = 0;
  endtask

  task automatic drain();
    int n;
    rand_ready = 0; out_ready = 1; n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin tick(); n++; end
    chk("drain_done", (n < 3000), 1);
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW+1:0] w;
    logic [DW-1:0] A, B, C;
    int nh;
    A = 54'h1_2345_6789_ABCD; B = 54'h2_0000_0000_0001; C = 54'h3_FFFF_0000_FFFF;
    reset = 0; repeat (3) tick(); reset = 1; tick();
    chk("reset_flags", {err_overflow, err_skip, out_valid}, 0);

    // Single event, three gapped words.
    seen.delete();
    ev(3'd5); put(A); tick(); put(B); tick(); tick(); put(C); close_none(); drain();
    chk("t1_len", seen.size(), 5);
    chk("t1_hdr", seen[0], {2'b01, 3'd5, 7'd3, 44'd0});
    chk("t1_a", seen[1], {2'b00, A});
    chk("t1_b", seen[2], {2'b00, B});
    chk("t1_c", seen[3], {2'b00, C});
    w = seen[4];
    chk("t1_trl", w[DW+1:16], {2'b10, 3'd5, 7'd3, 1'b0, 7'd0, 20'd0});

    // Zero-word event.
    seen.delete();
    ev(3'd2); close_none(); drain();
    chk("t2_len", seen.size(), 2);
    chk("t2_hdr", seen[0], {2'b01, 3'd2, 7'd0, 44'd0});
    w = seen[1];
    chk("t2_trl", w[DW+1:16], {2'b10, 3'd2, 7'd0, 1'b0, 7'd0, 20'd0});
`ifdef FRAMER_CRC_EN
    chk("t2_crc", w[15:0], 16'hFFFF);
`else
    chk("t2_crc", w[15:0], 16'h0000);
`endif

    // FIFO overflow: 70 words into 64 slots.
    seen.delete(); out_ready = 0;
    ev(3'd1);
    for (int i = 0; i < 70; i++) put(rnd());
    close_none();
    chk("t3_ovf_flag", err_overflow, 1);
    drain();
    chk("t3_len", seen.size(), 66);
    w = seen[0];
    chk("t3_hdr_cnt", w[DW-4 -: 7], 64);
    w = seen[seen.size() - 1];
    chk("t3_trl_ovf", w[DW-11], 1);
    chk("t3_trl_drop", w[DW-12 -: 7], 6);

    // Six back-to-back events with a stalled link.
    seen.delete(); out_ready = 0;
    for (int b = 1; b <= 6; b++) begin ev(3'(b)); put(rnd()); tick(); end
    repeat (4) tick();
    chk("t4_skip_flag", err_skip, 1);
    drain();
    nh = 0;
    foreach (seen[k]) begin
      w = seen[k];
      if (w[DW+1:DW] == 2'b01) begin
        nh++;
        chk("t4_hdr_bx", w[DW-1 -: 3], nh);
      end
    end
    chk("t4_frames", nh, 4);

    // Ten words drained under random back-pressure.
    seen.delete(); out_ready = 0;
    ev(3'd4);
    for (int i = 0; i < 10; i++) begin put(rnd()); repeat ($urandom_range(0, 2)) tick(); end
    close_none();
    rand_ready = 1; repeat (80) tick();
    drain();
    chk("t5_len", seen.size(), 12);

    // Reset while the data phase is in progress.
    seen.delete(); out_ready = 0;
    ev(3'd6);
    for (int i = 0; i < 8; i++) put(rnd());
    close_none();
    out_ready = 1; tick(); tick();
    reset = 0; tick(); reset = 1;
    chk("t6_seen_before_reset", seen.size(), 2);
    tick();
    chk("t6_after_reset", {err_overflow, err_skip, out_valid}, 0);
    seen.delete();
    ev(3'd7); put(A); put(B); close_none(); drain();
    chk("t6_len", seen.size(), 4);
    chk("t6_hdr", seen[0], {2'b01, 3'd7, 7'd2, 44'd0});

    // Random traffic with random link readiness.
    rand_ready = 1;
    for (int e = 0; e < 25; e++) begin
      ev(3'($urandom_range(0, 7)));
      for (int i = $urandom_range(0, 14); i > 0; i--) begin
        put(rnd());
        repeat ($urandom_range(0, 2)) tick();
      end
      if ($urandom_range(0, 1) == 1) close_none();
    end
    close_none();
    drain();
    chk("final_exp_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
